// File: rtl/wb_arb_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package wb_arb_pkg;

  localparam int NREQ  = 3;
  localparam int WIDTH = 32;

  localparam int AU_IDX = 0;
  localparam int MU_IDX = 1;
  localparam int DU_IDX = 2;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } wb_entry_t;

endpackage

// File: rtl/wb_arb_select.sv
// One-hot grant selection for the write-port arbiter.
// WB_ARB_ROUND_ROBIN_EN selects rotating priority; otherwise fixed DU > MU > AU.
module wb_arb_select
  import wb_arb_pkg::*;
(
  input  logic [NREQ-1:0] valid_i,
  input  logic [NREQ-1:0] age_i,
  input  logic [NREQ-1:0] conflict_i,
  input  logic [1:0]      ptr_i,
  output logic [NREQ-1:0] grant_o
);

  // A buffer queued behind an older same-rd buffer must wait for it.
  logic [NREQ-1:0] elig;
  assign elig = valid_i & ~(age_i & conflict_i);

`ifdef WB_ARB_ROUND_ROBIN_EN
  always_comb begin
    logic found;
    int   idx;
    grant_o = '0;
    found   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_i) + k) % NREQ;
      if (!found && elig[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end
`else
  // NOTE: combinational blocks use blocking '=' and assign a default first, so no latch is inferred.
  always_comb begin
    grant_o = '0;
    if (elig[DU_IDX])      grant_o[DU_IDX] = 1'b1;
    else if (elig[MU_IDX]) grant_o[MU_IDX] = 1'b1;
    else if (elig[AU_IDX]) grant_o[AU_IDX] = 1'b1;
  end

  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
`endif

endmodule

// File: rtl/wb_port_arbiter.sv
// Three-unit register-file write-port arbiter with 1-entry holding buffers.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: fixed priority).
module wb_port_arbiter
  import wb_arb_pkg::*;
(
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        flush,
  input  logic [NREQ-1:0]             req_wen,
  input  logic [NREQ-1:0][4:0]        req_rd,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_wdata,
  output logic [NREQ-1:0]             busy,
  output logic                        rf_wen,
  output logic [4:0]                  rf_rd,
  output logic [WIDTH-1:0]            rf_wdata,
  output logic [NREQ-1:0]             grant
);

  logic [NREQ-1:0]  valid_q, valid_d;
  logic [NREQ-1:0]  age_q, age_d;
  logic [NREQ-1:0]  accept, stay, conflict;
  logic [4:0]       rd_q    [NREQ];
  logic [WIDTH-1:0] wdata_q [NREQ];
  logic [1:0]       ptr;
  wb_entry_t        sel;

  // conflict[i]: another valid buffer with the same rd that is not itself waiting.
  always_comb begin
    conflict = '0;
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < NREQ; j++)
        if (j != i && valid_q[j] && !age_q[j] && rd_q[j] == rd_q[i])
          conflict[i] = 1'b1;
  end

  wb_arb_select u_select (
    .valid_i    (valid_q),
    .age_i      (age_q),
    .conflict_i (conflict),
    .ptr_i      (ptr),
    .grant_o    (grant)
  );

  assign busy = valid_q & ~grant;
  assign stay = valid_q & ~grant & {NREQ{~flush}};

  // age_d[i] marks a buffer loaded behind a surviving buffer with the same rd.
  always_comb begin
    logic older;
    accept  = '0;
    valid_d = '0;
    age_d   = '0;
    older   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      accept[i]  = req_wen[i] & ~busy[i] & ~flush & (req_rd[i] != 5'd0);
      valid_d[i] = accept[i] | stay[i];
      older      = 1'b0;
      for (int j = 0; j < NREQ; j++)
        if (j != i && stay[j] && rd_q[j] == (accept[i] ? req_rd[i] : rd_q[i]))
          older = 1'b1;
      age_d[i] = accept[i] ? older : (stay[i] & age_q[i] & older);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      age_q   <= '0;
    end else begin
      valid_q <= valid_d;
      age_q   <= age_d;
    end
  end

  // NOTE: payload storage has no reset; every read of it is qualified by valid_q.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NREQ; i++) begin
      if (accept[i]) begin
        rd_q[i]    <= req_rd[i];
        wdata_q[i] <= req_wdata[i];
      end
    end
  end

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) ptr_d = 2'(i);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = 2'd0;
`endif

  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel.valid = 1'b1;
        sel.rd    = rd_q[i];
        sel.wdata = wdata_q[i];
      end
    end
  end

  assign rf_wen   = sel.valid;
  assign rf_rd    = sel.rd;
  assign rf_wdata = sel.wdata;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus random traffic
// compared against a timestamp-based reference model.
module tb_wb_port_arbiter;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             flush;
  logic [2:0]       req_wen;
  logic [2:0][4:0]  req_rd;
  logic [2:0][31:0] req_wdata;
  logic [2:0]       busy;
  logic             rf_wen;
  logic [4:0]       rf_rd;
  logic [31:0]      rf_wdata;
  logic [2:0]       grant;

  always #5 CLK = ~CLK;

  wb_port_arbiter dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .flush     (flush),
    .req_wen   (req_wen),
    .req_rd    (req_rd),
    .req_wdata (req_wdata),
    .busy      (busy),
    .rf_wen    (rf_wen),
    .rf_rd     (rf_rd),
    .rf_wdata  (rf_wdata),
    .grant     (grant)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: buffers stamped with the edge number on which they were loaded.
  bit          m_valid [3];
  logic [4:0]  m_rd    [3];
  logic [31:0] m_data  [3];
  int          m_ts    [3];
  int          m_ptr;
  int          m_edge;

  logic [2:0]  obs_grant, obs_busy;
  logic        obs_wen;
  logic [4:0]  obs_rd;
  logic [31:0] obs_wdata;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 1'b0;
      m_ts[i]    = 0;
    end
    m_ptr = 0;
  endfunction

  function automatic int model_pick();
    int order [3];
    int i;
    bit blocked;
`ifdef WB_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 3; k++) order[k] = (m_ptr + 1 + k) % 3;
`else
    order = '{2, 1, 0};
`endif
    for (int k = 0; k < 3; k++) begin
      i = order[k];
      blocked = 1'b0;
      for (int j = 0; j < 3; j++)
        if (j != i && m_valid[j] && m_rd[j] == m_rd[i] && m_ts[j] < m_ts[i])
          blocked = 1'b1;
      if (m_valid[i] && !blocked) return i;
    end
    return -1;
  endfunction

  function automatic logic [2:0] model_busy();
    logic [2:0] b;
    int g;
    g = model_pick();
    for (int i = 0; i < 3; i++) b[i] = m_valid[i] && (g != i);
    return b;
  endfunction

  // One clock cycle: drive inputs, compare outputs, then advance the model across the edge.
  task automatic cycle(input logic fl, input logic [2:0] wen,
                       input logic [2:0][4:0] rd, input logic [2:0][31:0] wd);
    int         g;
    logic [2:0] eg, eb;
    bit         acc;
    @(negedge CLK);
    flush     = fl;
    req_wen   = wen;
    req_rd    = rd;
    req_wdata = wd;
    #1;
    g  = model_pick();
    eb = model_busy();
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    check("grant",    grant,    eg);
    check("busy",     busy,     eb);
    check("rf_wen",   rf_wen,   g >= 0);
    check("rf_rd",    rf_rd,    (g >= 0) ? m_rd[g]   : 5'd0);
    check("rf_wdata", rf_wdata, (g >= 0) ? m_data[g] : 32'd0);
    obs_grant = grant;
    obs_busy  = busy;
    obs_wen   = rf_wen;
    obs_rd    = rf_rd;
    obs_wdata = rf_wdata;
    for (int i = 0; i < 3; i++) begin
      acc = wen[i] && !eb[i] && !fl && rd[i] != 5'd0;
      if (fl) m_valid[i] = 1'b0;
      else if (acc) begin
        m_valid[i] = 1'b1;
        m_rd[i]    = rd[i];
        m_data[i]  = wd[i];
        m_ts[i]    = m_edge;
      end else if (g == i) m_valid[i] = 1'b0;
    end
    if (g >= 0) m_ptr = g;
    m_edge++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 3'b000, '0, '0);
  endtask

  int               rd_tab [3][4] = '{'{0, 1, 7, 8}, '{0, 2, 7, 9}, '{0, 3, 8, 9}};
  logic [2:0]       cur_wen, mb;
  logic [2:0][4:0]  cur_rd;
  logic [2:0][31:0] cur_wd;
  int               b0_cnt, b1_cnt;
  int               gq [$];

  initial begin
    nRST = 1'b0; flush = 1'b0; req_wen = '0; req_rd = '0; req_wdata = '0;
    model_reset();
    m_edge = 1;
    #12;
    check("rst_busy",  busy,     3'b000);
    check("rst_grant", grant,    3'b000);
    check("rst_wen",   rf_wen,   1'b0);
    check("rst_rd",    rf_rd,    5'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // Single uncontended AU write.
    cycle(1'b0, 3'b001, {5'd0, 5'd0, 5'd5}, {32'd0, 32'd0, 32'hDEADBEEF});
    idle(1);
    check("single_wen",   obs_wen,   1'b1);
    check("single_rd",    obs_rd,    5'd5);
    check("single_wdata", obs_wdata, 32'hDEADBEEF);
    check("single_busy",  obs_busy,  3'b000);
    idle(1);

    // All three units at once.
    cycle(1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hD0, 32'hC0, 32'hA0});
    b0_cnt = 0; b1_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      idle(1);
      b0_cnt += int'(obs_busy[0]);
      b1_cnt += int'(obs_busy[1]);
      gq.push_back(int'(obs_rd));
    end
`ifndef WB_ARB_ROUND_ROBIN_EN
    check("all3_order", {gq[0][4:0], gq[1][4:0], gq[2][4:0]}, {5'd3, 5'd2, 5'd1});
    check("all3_busy0", b0_cnt, 2);
    check("all3_busy1", b1_cnt, 1);
`endif
    gq.delete();
    idle(1);

    // Same rd: AU accepted one edge before DU must be written first.
    cycle(1'b0, 3'b011, {5'd0, 5'd2, 5'd7}, {32'd0, 32'h22, 32'hA7});
    cycle(1'b0, 3'b100, {5'd7, 5'd0, 5'd0}, {32'hD7, 32'd0, 32'd0});
    idle(1);
    check("order_first",  obs_wdata, 32'hA7);
    idle(1);
    check("order_second", obs_wdata, 32'hD7);
    idle(1);

    // rd = 0 is dropped.
    cycle(1'b0, 3'b001, '0, {32'd0, 32'd0, 32'h1234});
    idle(1);
    check("rd0_wen",  obs_wen,  1'b0);
    check("rd0_busy", obs_busy, 3'b000);

    // Flush with two valid buffers.
    cycle(1'b0, 3'b101, {5'd3, 5'd0, 5'd1}, {32'hF3, 32'd0, 32'hF1});
    cycle(1'b1, 3'b000, '0, '0);
    check("flush_wen", obs_wen, 1'b1);
    check("flush_rd",  obs_rd,  5'd3);
    idle(1);
    check("post_flush_wen",  obs_wen,  1'b0);
    check("post_flush_busy", obs_busy, 3'b000);

`ifdef WB_ARB_ROUND_ROBIN_EN
    // Continuous requests from all units rotate the grant.
    for (int k = 0; k < 9; k++) begin
      cycle(1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {$urandom, $urandom, $urandom});
      if (k > 0) begin
        for (int i = 0; i < 3; i++) if (obs_grant[i]) gq.push_back(i);
      end
    end
    for (int k = 2; k < gq.size(); k++)
      check("rr_window", (gq[k] != gq[k-1]) && (gq[k] != gq[k-2]) && (gq[k-1] != gq[k-2]), 1'b1);
    gq.delete();
    idle(3);
`endif

    // Reset mid-transfer with three valid buffers.
    cycle(1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hB3, 32'hB2, 32'hB1});
    @(negedge CLK);
    #2;
    nRST = 1'b0;
    req_wen = '0;
    #1;
    check("mid_rst_busy",  busy,     3'b000);
    check("mid_rst_grant", grant,    3'b000);
    check("mid_rst_wen",   rf_wen,   1'b0);
    check("mid_rst_wdata", rf_wdata, 32'd0);
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    idle(1);
    check("after_rst_wen", obs_wen, 1'b0);
    idle(2);

    // Random traffic; busy units hold their request stable.
    cur_wen = '0; cur_rd = '0; cur_wd = '0;
    for (int n = 0; n < 400; n++) begin
      mb = model_busy();
      for (int i = 0; i < 3; i++) begin
        if (!mb[i]) begin
          cur_wen[i] = ($urandom_range(0, 3) != 0);
          cur_rd[i]  = 5'(rd_tab[i][$urandom_range(0, 3)]);
          cur_wd[i]  = $urandom;
        end
      end
      cycle($urandom_range(0, 15) == 0, cur_wen, cur_rd, cur_wd);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
